// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and small helpers shared by the scanout blocks.
package vga_timing_pkg;

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_FP    = 10'd16;
    localparam logic [9:0] H_SYNC  = 10'd96;
    localparam logic [9:0] H_BP    = 10'd48;
    localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_LAST  = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_S = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_E = H_SYNC_S + H_SYNC - 10'd1;

    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_FP    = 10'd10;
    localparam logic [9:0] V_SYNC  = 10'd2;
    localparam logic [9:0] V_BP    = 10'd33;
    localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_LAST  = V_TOTAL - 10'd1;
    localparam logic [9:0] V_SYNC_S = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_E = V_SYNC_S + V_SYNC - 10'd1;

    localparam int ADDR_W = 15;
    localparam logic [ADDR_W-1:0] FB_W     = 15'd160;
    localparam logic [ADDR_W-1:0] FB_H     = 15'd120;
    localparam logic [ADDR_W-1:0] FB_DEPTH = 15'd19200;

    typedef logic [11:0] rgb12_t;

    // 80-pixel-wide colour bar index for a visible column
    function automatic logic [2:0] bar_index(input logic [9:0] h);
        logic [2:0] k;
        if (h < 10'd80)       k = 3'd0;
        else if (h < 10'd160) k = 3'd1;
        else if (h < 10'd240) k = 3'd2;
        else if (h < 10'd320) k = 3'd3;
        else if (h < 10'd400) k = 3'd4;
        else if (h < 10'd480) k = 3'd5;
        else if (h < 10'd560) k = 3'd6;
        else                  k = 3'd7;
        return k;
    endfunction

    function automatic rgb12_t bar_rgb(input logic [2:0] k);
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage 0 of the scanout: h/v raster counters and the decoded enable/sync strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pix_ce_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       de0_o,
    output logic       hs0_o,
    output logic       vs0_o,
    output logic       in_vblank_o,
    output logic       line_end_o,
    output logic       frame_end_o
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Raster counter next state
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce_i) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Raster counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign de0_o       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs0_o       = !((h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E));
    assign vs0_o       = !((v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E));
    assign in_vblank_o = (v_cnt_q >= V_VIS);
    assign line_end_o  = (h_cnt_q == H_LAST);
    assign frame_end_o = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/vga_scanout_160x120.sv
// VGA 640x480@60 scanout of a 160x120x12 framebuffer with 4x4 pixel replication.
// Optional SCANOUT_PATTERN_EN: pattern_sel=1 replaces pixel data by 8 colour bars.
module vga_scanout_160x120
    import vga_timing_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic [11:0]       rd_data,
    input  logic              pattern_sel,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic              in_vblank
);

    logic [9:0] h_cnt_s, v_cnt_s;
    logic       de0_s, hs0_s, vs0_s, in_vblank_s, line_end_s, frame_end_s;

    vga_timing_gen u_timing (
        .clk_i       (clk),
        .reset_i     (reset),
        .pix_ce_i    (pix_ce),
        .h_cnt_o     (h_cnt_s),
        .v_cnt_o     (v_cnt_s),
        .de0_o       (de0_s),
        .hs0_o       (hs0_s),
        .vs0_o       (vs0_s),
        .in_vblank_o (in_vblank_s),
        .line_end_o  (line_end_s),
        .frame_end_o (frame_end_s)
    );

    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic              de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, first1_q, first1_d;
    rgb12_t            rgb_q, rgb_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
`ifdef SCANOUT_PATTERN_EN
    logic [2:0]        bar1_q, bar1_d;
`else
    logic              unused_pattern_sel_s;
    assign unused_pattern_sel_s = pattern_sel;
`endif

    // Stage 1: row_base steps by one framebuffer row after every fourth visible line
    always_comb begin
        row_base_d = row_base_q;
        addr_d     = addr_q;
        de1_d      = de1_q;
        hs1_d      = hs1_q;
        vs1_d      = vs1_q;
        first1_d   = first1_q;
`ifdef SCANOUT_PATTERN_EN
        bar1_d     = bar1_q;
`endif
        if (pix_ce) begin
            de1_d    = de0_s;
            hs1_d    = hs0_s;
            vs1_d    = vs0_s;
            first1_d = (h_cnt_s == 10'd0) && (v_cnt_s == 10'd0);
`ifdef SCANOUT_PATTERN_EN
            bar1_d   = bar_index(h_cnt_s);
`endif
            if (de0_s) begin
                addr_d = row_base_q + {7'd0, h_cnt_s[9:2]};
            end else begin
                addr_d = addr_q;
            end
            if (frame_end_s) begin
                row_base_d = {ADDR_W{1'b0}};
            end else if (line_end_s && !in_vblank_s && (v_cnt_s[1:0] == 2'b11)) begin
                row_base_d = row_base_q + FB_W;
            end else begin
                row_base_d = row_base_q;
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Stage 2: pins; frame_start lasts only the clk in which pixel (0,0) loads
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        fs_d    = 1'b0;
        if (pix_ce) begin
            hsync_d = hs1_q;
            vsync_d = vs1_q;
            fs_d    = first1_q;
            if (!de1_q) begin
                rgb_d = 12'h000;
`ifdef SCANOUT_PATTERN_EN
            end else if (pattern_sel) begin
                rgb_d = bar_rgb(bar1_q);
`endif
            end else begin
                rgb_d = rd_data;
            end
        end else begin
            fs_d = 1'b0;
        end
    end

    // Pipeline registers; reset dominates pix_ce
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base_q <= {ADDR_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            de1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            first1_q   <= 1'b0;
            rgb_q      <= 12'h000;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            fs_q       <= 1'b0;
`ifdef SCANOUT_PATTERN_EN
            bar1_q     <= 3'd0;
`endif
        end else begin
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            de1_q      <= de1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            first1_q   <= first1_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
`ifdef SCANOUT_PATTERN_EN
            bar1_q     <= bar1_d;
`endif
        end
    end

    assign addr        = addr_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign in_vblank   = in_vblank_s;

endmodule
